// File: rtl/cla_seq_pkg.sv
// Shared types and default sizing for the multi-word carry-lookahead sequencer.
package cla_seq_pkg;

    localparam int DEF_N     = 32;
    localparam int DEF_WORDS = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cla_slice.sv
// N-bit combinational adder: 4-bit lookahead cells whose group carries chain cell to cell.
module cla_slice #(
    parameter int N = 32
) (
    input  logic [N-1:0] i_a,
    input  logic [N-1:0] i_b,
    input  logic         i_cin,
    output logic [N-1:0] o_sum,
    output logic         o_cout
);

    localparam int CELLS = N / 4;

    logic [CELLS:0] w_c;

    assign w_c[0] = i_cin;

    for (genvar k = 0; k < CELLS; k++) begin : g_cell
        logic [3:0] w_g;
        logic [3:0] w_p;
        logic [4:0] w_cc;

        assign w_g = i_a[4*k +: 4] & i_b[4*k +: 4];
        assign w_p = i_a[4*k +: 4] ^ i_b[4*k +: 4];

        // Every internal carry is a flat sum of products of the cell carry-in.
        assign w_cc[0] = w_c[k];
        assign w_cc[1] = w_g[0] | (w_p[0] & w_cc[0]);
        assign w_cc[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_cc[0]);
        assign w_cc[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                       | (w_p[2] & w_p[1] & w_p[0] & w_cc[0]);
        assign w_cc[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
                       | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
                       | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_cc[0]);

        assign o_sum[4*k +: 4] = w_p ^ w_cc[3:0];
        assign w_c[k+1]        = w_cc[4];
    end

    assign o_cout = w_c[CELLS];

endmodule

// File: rtl/cla_multiword_seq.sv
// Wide add/subtract done one N-bit slice per cycle through a single shared
// lookahead slice, with the carry held in a register between slices.
module cla_multiword_seq
    import cla_seq_pkg::*;
#(
    parameter int N     = DEF_N,
    parameter int WORDS = DEF_WORDS
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [N*WORDS-1:0]   in_a,
    input  logic [N*WORDS-1:0]   in_b,
    input  logic                 in_sub,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [N*WORDS-1:0]   out_sum,
    output logic                 out_cout,
    output logic                 out_of,
    output logic                 busy
);

    localparam int W  = N * WORDS;
    localparam int IW = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam logic [IW-1:0] LAST = IW'(WORDS - 1);

    state_t          r_state;
    logic [IW-1:0]   r_idx;
    logic            r_carry;
    logic [W-1:0]    r_a;
    logic [W-1:0]    r_b;
    logic [W-1:0]    r_sum;
    logic            r_cout;
    logic            r_of;

    int              w_base;
    logic [N-1:0]    w_sa;
    logic [N-1:0]    w_sb;
    logic [N-1:0]    w_ss;
    logic            w_co;

    assign w_base = int'(r_idx) * N;
    assign w_sa   = r_a[w_base +: N];
    assign w_sb   = r_b[w_base +: N];

    cla_slice #(.N(N)) u_slice (
        .i_a    (w_sa),
        .i_b    (w_sb),
        .i_cin  (r_carry),
        .o_sum  (w_ss),
        .o_cout (w_co)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_carry <= 1'b0;
            r_a     <= '0;
            r_b     <= '0;
            r_sum   <= '0;
            r_cout  <= 1'b0;
            r_of    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // Subtract is A + ~B + 1: invert B here, the +1 enters as carry-in.
                    if (in_valid) begin
                        r_a     <= in_a;
                        r_b     <= in_sub ? ~in_b : in_b;
                        r_carry <= in_sub;
                        r_idx   <= '0;
                        r_state <= ST_RUN;
                    end
                end
                ST_RUN: begin
                    r_sum[w_base +: N] <= w_ss;
                    r_carry            <= w_co;
                    if (r_idx == LAST) begin
                        r_cout  <= w_co;
                        r_of    <= (r_a[W-1] == r_b[W-1]) && (w_ss[N-1] != r_a[W-1]);
                        r_idx   <= '0;
                        r_state <= ST_DONE;
                    end else begin
                        r_idx <= r_idx + IW'(1);
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == ST_IDLE);
    assign out_valid = (r_state == ST_DONE);
    assign busy      = (r_state != ST_IDLE);
    assign out_sum   = r_sum;
    assign out_cout  = r_cout;
    assign out_of    = r_of;

endmodule
